// File: rtl/spiword_rx.sv
// SPI word responder: oversamples SCL/CSn/MOSI in the clk domain, assembles
// MSB-first words sampled on SCL rise and shifts a reply word out on MISO.
module spiword_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_csn,
    input  logic             i_scl,
    input  logic             i_mosi,
    output logic             o_miso,
    input  logic [WIDTH-1:0] i_tx_word,
    output logic             o_tx_ack,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LP_WIDTH = CW'(WIDTH);
    localparam logic [CW-1:0] LP_ZERO  = CW'(0);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ACTIVE    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_scl_prev;
    logic                   r_csn_prev;
    logic [CW-1:0]          r_bitcnt;
    logic                   r_rose;
    logic [WIDTH-1:0]       r_rx_sh;
    logic [WIDTH-1:0]       r_tx_sh;
    logic [WIDTH-1:0]       r_rx_data;
    logic                   r_rx_valid;
    logic                   r_tx_ack;
    logic                   r_frame_err;
    logic                   r_miso;
    logic                   r_busy;

    logic                   w_scl;
    logic                   w_csn;
    logic                   w_mosi;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_csn_rise;
    logic                   w_csn_fall;
    logic [CW-1:0]          w_bitcnt_inc;
    logic [WIDTH-1:0]       w_rx_shifted;
    logic [CW-1:0]          w_bitcnt_nxt;
    logic                   w_rose_nxt;
    logic [WIDTH-1:0]       w_rx_sh_nxt;
    logic [WIDTH-1:0]       w_tx_sh_nxt;
    logic [WIDTH-1:0]       w_rx_data_nxt;
    logic                   w_rx_valid_nxt;
    logic                   w_tx_ack_nxt;
    logic                   w_frame_err_nxt;
    logic                   w_miso_nxt;
    logic                   w_busy_nxt;

    assign w_scl        = r_scl_sync[SYNC_STAGES-1];
    assign w_csn        = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_scl_rise   = w_scl & ~r_scl_prev;
    assign w_scl_fall   = ~w_scl & r_scl_prev;
    assign w_csn_rise   = w_csn & ~r_csn_prev;
    assign w_csn_fall   = ~w_csn & r_csn_prev;
    assign w_bitcnt_inc = r_bitcnt + CW'(1);
    assign w_rx_shifted = {r_rx_sh[WIDTH-2:0], w_mosi};

    // Input synchronisers and one-cycle-delayed copies for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync  <= '0;
            r_csn_sync  <= '0;
            r_mosi_sync <= '0;
            r_scl_prev  <= 1'b0;
            r_csn_prev  <= 1'b0;
        end else begin
            r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], i_csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_scl_prev  <= w_scl;
            r_csn_prev  <= w_csn;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update; a CSn rise takes priority over any SCL edge
    always_comb begin
        w_state_nxt     = r_state;
        w_bitcnt_nxt    = r_bitcnt;
        w_rose_nxt      = r_rose;
        w_rx_sh_nxt     = r_rx_sh;
        w_tx_sh_nxt     = r_tx_sh;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_tx_ack_nxt    = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            ST_WAIT_IDLE: begin
                if (w_csn) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_csn_fall) begin
                    w_state_nxt  = ST_ACTIVE;
                    w_tx_sh_nxt  = i_tx_word;
                    w_tx_ack_nxt = 1'b1;
                    w_bitcnt_nxt = LP_ZERO;
                    w_rose_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_csn_rise) begin
                    w_state_nxt     = ST_IDLE;
                    w_frame_err_nxt = (r_bitcnt != LP_ZERO);
                    w_bitcnt_nxt    = LP_ZERO;
                end else if (w_scl_rise) begin
                    w_rx_sh_nxt = w_rx_shifted;
                    w_rose_nxt  = 1'b1;
                    if (w_bitcnt_inc == LP_WIDTH) begin
                        w_rx_data_nxt  = w_rx_shifted;
                        w_rx_valid_nxt = 1'b1;
                        w_bitcnt_nxt   = LP_ZERO;
                    end else begin
                        w_bitcnt_nxt = w_bitcnt_inc;
                    end
                end else if (w_scl_fall && r_rose) begin
                    // A fall with bitcnt==0 is a word boundary: fetch the next reply
                    if (r_bitcnt == LP_ZERO) begin
                        w_tx_sh_nxt  = i_tx_word;
                        w_tx_ack_nxt = 1'b1;
                    end else begin
                        w_tx_sh_nxt = {r_tx_sh[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == ST_ACTIVE);
        w_miso_nxt = w_busy_nxt ? w_tx_sh_nxt[WIDTH-1] : 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bitcnt    <= LP_ZERO;
            r_rose      <= 1'b0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_bitcnt    <= w_bitcnt_nxt;
            r_rose      <= w_rose_nxt;
            r_rx_sh     <= w_rx_sh_nxt;
            r_tx_sh     <= w_tx_sh_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_ack    <= w_tx_ack_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_miso      <= w_miso_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign o_miso      = r_miso;
    assign o_tx_ack    = r_tx_ack;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_spiword_rx.sv
// Bench for spiword_rx: behaves as the SPI word master and compares received
// words, reply bits, pulse counts and latency against a word-level model.
`timescale 1ns/1ps
module tb_spiword_rx;

    localparam int W    = 16;
    localparam int SS   = 2;
    localparam int PER  = 10;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          csn;
    logic          scl;
    logic          mosi;
    logic          miso;
    logic [W-1:0]  tx_word;
    logic          tx_ack;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Word-level model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_last = 16'h0000;
    int           exp_rxv  = 0;
    int           exp_ack  = 0;
    int           exp_ferr = 0;
    int           n_rxv    = 0;
    int           n_ack    = 0;
    int           n_ferr   = 0;
    longint       t_last_rise = 0;
    logic [W-1:0] fw [0:3];
    logic [W-1:0] fr [0:3];
    logic         p_rxv = 1'b0, p_ack = 1'b0, p_ferr = 1'b0;

    always #(PER/2) clk = ~clk;

    spiword_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_csn      (csn),
        .i_scl      (scl),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .i_tx_word  (tx_word),
        .o_tx_ack   (tx_ack),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_frame_err(frame_err),
        .o_busy     (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor, sampled 1ns after each rising edge
    always @(posedge clk) begin
        #1;
        if (rx_valid) begin
            n_rxv++;
            check_eq("rxv_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check_eq("rx_data", {16'd0, rx_data}, {16'd0, exp_q.pop_front()});
            check_eq("latency", 32'(($time - 1 - t_last_rise - PER/2) / PER), SS);
            check_eq("rxv_ferr_excl", {31'd0, frame_err}, 32'd0);
            if (p_rxv) check_eq("rxv_width", 32'd2, 32'd1);
        end
        if (tx_ack) begin
            n_ack++;
            if (p_ack) check_eq("ack_width", 32'd2, 32'd1);
        end
        if (frame_err) begin
            n_ferr++;
            if (p_ferr) check_eq("ferr_width", 32'd2, 32'd1);
        end
        p_rxv  = rx_valid;
        p_ack  = tx_ack;
        p_ferr = frame_err;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input logic exp_miso, input logic do_chk);
        scl  = 1'b0;
        mosi = b;
        wait_neg(HALF);
        if (do_chk) check_eq("miso_bit", {31'd0, miso}, {31'd0, exp_miso});
        scl = 1'b1;
        t_last_rise = $time;
        wait_neg(HALF);
    endtask

    // One CSn frame of nbits using fw/fr; model updated from word-level rules
    task automatic do_frame(input int nbits);
        int nfull = nbits / W;
        for (int k = 0; k < nfull; k++) begin
            exp_q.push_back(fw[k]);
            exp_last = fw[k];
        end
        exp_rxv  += nfull;
        exp_ack  += (nbits + W - 1) / W;
        exp_ferr += (nbits % W != 0) ? 1 : 0;
        tx_word = fr[0];
        wait_neg(1);
        csn = 1'b0;
        wait_neg(HALF);
        check_eq("busy_active", {31'd0, busy}, 32'd1);
        for (int b = 0; b < nbits; b++) begin
            logic [W-1:0] dw, rw;
            dw = fw[b / W];
            rw = fr[b / W];
            if (b % W == 0) tx_word = rw;
            drive_bit(dw[W-1-(b%W)], rw[W-1-(b%W)], 1'b1);
        end
        csn = 1'b1;
        wait_neg(HALF);
        check_eq("busy_end", {31'd0, busy}, 32'd0);
        check_eq("rx_hold", {16'd0, rx_data}, {16'd0, exp_last});
        check_eq("miso_idle", {31'd0, miso}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; csn = 1'b1; scl = 1'b1; mosi = 1'b0; tx_word = 16'h0000;
        wait_neg(4);
        check_eq("rst_miso", {31'd0, miso}, 32'd1);
        check_eq("rst_rx_data", {16'd0, rx_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_pulses", {29'd0, rx_valid, tx_ack, frame_err}, 32'd0);
        rst = 1'b0;
        wait_neg(6);

        // Single word, then 0x8001 reply pattern
        fw[0] = 16'hA5C3; fr[0] = 16'h8001;
        do_frame(16);
        // Back-to-back words
        fw[0] = 16'h0001; fw[1] = 16'hFFFF; fw[2] = 16'h1234;
        fr[0] = 16'($urandom); fr[1] = 16'($urandom); fr[2] = 16'($urandom);
        do_frame(48);
        // Truncated frame then a full word
        fw[0] = 16'($urandom); fr[0] = 16'($urandom);
        do_frame(7);
        fw[0] = 16'h5A5A; fr[0] = 16'($urandom);
        do_frame(16);

        // Reset mid-frame with CSn held low
        tx_word = 16'hC0DE;
        exp_ack += 1;
        wait_neg(1);
        csn = 1'b0;
        wait_neg(HALF);
        for (int b = 0; b < 5; b++) drive_bit(1'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        wait_neg(2);
        check_eq("mid_rst_miso", {31'd0, miso}, 32'd1);
        check_eq("mid_rst_rx_data", {16'd0, rx_data}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_pulses", {29'd0, rx_valid, tx_ack, frame_err}, 32'd0);
        rst = 1'b0;
        exp_last = 16'h0000;
        for (int b = 0; b < 11; b++) drive_bit(1'($urandom), 1'b0, 1'b0);
        check_eq("wait_idle_busy", {31'd0, busy}, 32'd0);
        csn = 1'b1;
        wait_neg(HALF);
        check_eq("wait_idle_rx", {16'd0, rx_data}, 32'd0);
        fw[0] = 16'hBEEF; fr[0] = 16'($urandom);
        do_frame(16);

        // SCL/MOSI noise with CSn high
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            scl  = 1'($urandom);
            mosi = 1'($urandom);
        end
        scl = 1'b1;
        wait_neg(HALF);
        check_eq("noise_rx_hold", {16'd0, rx_data}, {16'd0, exp_last});

        // Randomised frames, some truncated
        for (int f = 0; f < 6; f++) begin
            int nw, part;
            nw   = $urandom_range(1, 3);
            part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
            for (int k = 0; k < 4; k++) begin
                fw[k] = 16'($urandom);
                fr[k] = 16'($urandom);
            end
            do_frame(nw * W + part);
        end

        wait_neg(4);
        check_eq("rxv_count", n_rxv, exp_rxv);
        check_eq("ack_count", n_ack, exp_ack);
        check_eq("ferr_count", n_ferr, exp_ferr);
        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
